// File: rtl/tx_buffer_if.sv
// tx_buffer_if: host write port, transmitter handshake and status bundle of the transmit buffer
interface tx_buffer_if #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int FIFO_ADDR_W     = 4
);
    logic                       wr_valid_i;
    logic [MAX_UART_DATA_W-1:0] wr_data_i;
    logic                       wr_ready_o;
    logic                       flush_i;
    logic                       tx_en_i;
    logic                       tx_busy_i;
    logic                       tx_done_i;
    logic                       tx_start_o;
    logic [MAX_UART_DATA_W-1:0] tx_data_o;
    logic [FIFO_ADDR_W:0]       fifo_count_o;
    logic                       fifo_empty_o;
    logic                       fifo_full_o;
    logic                       overflow_o;
    logic                       tx_timeout_o;

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i, tx_en_i, tx_busy_i, tx_done_i,
        output wr_ready_o, tx_start_o, tx_data_o, fifo_count_o, fifo_empty_o,
               fifo_full_o, overflow_o, tx_timeout_o
    );

    modport master (
        output wr_valid_i, wr_data_i, flush_i, tx_en_i, tx_busy_i, tx_done_i,
        input  wr_ready_o, tx_start_o, tx_data_o, fifo_count_o, fifo_empty_o,
               fifo_full_o, overflow_o, tx_timeout_o
    );
endinterface

// File: rtl/tx_buffer.sv
// tx_buffer: circular byte FIFO feeding the UART transmitter one frame at a time; optional watchdog via TX_WATCHDOG_EN
module tx_buffer #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int FIFO_ADDR_W     = 4,
    parameter int WDOG_CYCLES     = 65535
) (
    input logic        clk_i,
    input logic        rst_ni,
    tx_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_ADDR_W;

    typedef enum logic {IDLE, WAIT_DONE} state_t;

    state_t                     state_q, state_d;
    logic [MAX_UART_DATA_W-1:0] mem [DEPTH];
    logic [FIFO_ADDR_W-1:0]     wptr_q, rptr_q;
    logic [FIFO_ADDR_W:0]       count_q;
    logic [MAX_UART_DATA_W-1:0] data_q;
    logic                       start_q, ovf_q;
    logic                       full, empty, wr_ready, push, pop, timeout;

    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 2 ** 20 - 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must lie in 1..2**20-1");
    end

    assign full     = count_q == (FIFO_ADDR_W + 1)'(DEPTH);
    assign empty    = count_q == '0;
    assign wr_ready = !full && !bus.flush_i;
    assign push     = bus.wr_valid_i && wr_ready;

    assign bus.wr_ready_o   = wr_ready;
    assign bus.tx_start_o   = start_q;
    assign bus.tx_data_o    = data_q;
    assign bus.fifo_count_o = count_q;
    assign bus.fifo_empty_o = empty;
    assign bus.fifo_full_o  = full;
    assign bus.overflow_o   = ovf_q;

`ifdef TX_WATCHDOG_EN
    logic [19:0] wd_q;
    logic        to_q;

    assign timeout          = state_q == WAIT_DONE && !bus.tx_done_i && wd_q == 20'(WDOG_CYCLES - 1);
    assign bus.tx_timeout_o = to_q;

    // cycles spent waiting for tx_done of the current frame, restarted by every pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= pop ? '0 : (state_q == WAIT_DONE ? wd_q + 20'd1 : wd_q);
            to_q <= timeout;
        end
    end
`else
    assign timeout          = 1'b0;
    assign bus.tx_timeout_o = 1'b0;
`endif

    // frame sequencer: start a frame from IDLE, then wait for the transmitter to finish it
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            pop     = bus.tx_en_i && !empty && !bus.tx_busy_i && !bus.flush_i;
            state_d = pop ? WAIT_DONE : IDLE;
        end else begin
            state_d = (bus.tx_done_i || timeout) ? IDLE : WAIT_DONE;
        end
    end

    // byte storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= bus.wr_data_i;
    end

    // pointers and occupancy; flush empties the buffer and wins over a concurrent write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + FIFO_ADDR_W'(push);
            rptr_q  <= rptr_q + FIFO_ADDR_W'(pop);
            count_q <= count_q + (FIFO_ADDR_W + 1)'(push) - (FIFO_ADDR_W + 1)'(pop);
        end
    end

    // registered frame outputs: start pulse, held frame data, dropped-write pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= pop;
            data_q  <= pop ? mem[rptr_q] : data_q;
            ovf_q   <= bus.wr_valid_i && full && !bus.flush_i;
        end
    end
endmodule

// File: tb/tb_tx_buffer.sv
// tb_tx_buffer: directed tests of tx_buffer against a queue-based frame model
module tb_tx_buffer;
    localparam int WD     = 100;
    localparam int TX_LAT = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       wr_valid = 1'b0, flush = 1'b0, tx_en = 1'b0;
    logic       man_busy = 1'b0, man_done = 1'b0, busy_m = 1'b0, done_m = 1'b0;
    logic       auto_tx = 1'b0, chk_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    int n_cmp = 0, n_bad = 0;
    int n_starts = 0, n_ovf = 0, n_to = 0;
    logic [7:0] sent[$];

    logic [7:0] mq[$];
    logic       m_in = 1'b0, m_start = 1'b0, m_ovf = 1'b0, m_to = 1'b0, m_go = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         cyc = 0, t_start = 0, m_sz = 0;

    always #5 clk_i = ~clk_i;

    tx_buffer_if #(.MAX_UART_DATA_W(8), .FIFO_ADDR_W(4)) bus ();

    tx_buffer #(.MAX_UART_DATA_W(8), .FIFO_ADDR_W(4), .WDOG_CYCLES(WD)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    assign bus.wr_valid_i = wr_valid;
    assign bus.wr_data_i  = wr_data;
    assign bus.flush_i    = flush;
    assign bus.tx_en_i    = tx_en;
    assign bus.tx_busy_i  = man_busy | busy_m;
    assign bus.tx_done_i  = man_done | done_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // model: buffer contents as a queue, one frame in flight, start/overflow/timeout as edge events
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_in = 1'b0; m_start = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_data = 8'h00; cyc = 0;
        end else begin
            m_sz    = mq.size();
            m_go    = !m_in && tx_en && m_sz > 0 && !(man_busy | busy_m) && !flush;
            m_ovf   = wr_valid && m_sz == 16 && !flush;
            m_to    = 1'b0;
            m_start = m_go;
            if (m_go) begin
                m_data  = mq.pop_front();
                m_in    = 1'b1;
                t_start = cyc;
            end else if (m_in) begin
                if (man_done | done_m) m_in = 1'b0;
`ifdef TX_WATCHDOG_EN
                else if (cyc - t_start == WD) begin
                    m_in = 1'b0;
                    m_to = 1'b1;
                end
`endif
            end
            if (flush) mq.delete();
            else if (wr_valid && m_sz < 16) mq.push_back(wr_data);
            cyc++;
        end
    end

    // compare every output against the model in the middle of each cycle
    always @(negedge clk_i) begin
        if (rst_ni && chk_en) begin
            check("count", 32'(bus.fifo_count_o), 32'(mq.size()));
            check("empty", 32'(bus.fifo_empty_o), 32'(mq.size() == 0));
            check("full", 32'(bus.fifo_full_o), 32'(mq.size() == 16));
            check("wr_ready", 32'(bus.wr_ready_o), 32'(mq.size() < 16 && !flush));
            check("tx_start", 32'(bus.tx_start_o), 32'(m_start));
            check("tx_data", 32'(bus.tx_data_o), 32'(m_data));
            check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
            check("timeout", 32'(bus.tx_timeout_o), 32'(m_to));
        end
    end

    // event monitor for the hand-computed checks
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.tx_start_o) begin
                n_starts++;
                sent.push_back(bus.tx_data_o);
            end
            if (bus.overflow_o) n_ovf++;
            if (bus.tx_timeout_o) n_to++;
        end
    end

    // transmitter model: busy after a start, tx_done pulse TX_LAT cycles later
    always begin
        tick();
        if (auto_tx && rst_ni && bus.tx_start_o) begin
            busy_m = 1'b1;
            repeat (TX_LAT) tick();
            done_m = 1'b1;
            tick();
            done_m = 1'b0;
            busy_m = 1'b0;
        end
    end

    initial begin
        int s0, s1, hit;
        repeat (3) tick();
        check("rst_start", 32'(bus.tx_start_o), 32'd0);
        check("rst_data", 32'(bus.tx_data_o), 32'd0);
        check("rst_count", 32'(bus.fifo_count_o), 32'd0);
        check("rst_empty", 32'(bus.fifo_empty_o), 32'd1);
        check("rst_full", 32'(bus.fifo_full_o), 32'd0);
        check("rst_ovf", 32'(bus.overflow_o), 32'd0);
        check("rst_to", 32'(bus.tx_timeout_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("rst_ready", 32'(bus.wr_ready_o), 32'd1);
        chk_en = 1'b1;

        // single byte through an empty buffer
        tx_en   = 1'b1;
        auto_tx = 1'b1;
        put(8'hAA);
        check("t1_count_in", 32'(bus.fifo_count_o), 32'd1);
        tick();
        check("t1_start", 32'(bus.tx_start_o), 32'd1);
        check("t1_data", 32'(bus.tx_data_o), 32'hAA);
        check("t1_count_out", 32'(bus.fifo_count_o), 32'd0);
        tick();
        check("t1_start_end", 32'(bus.tx_start_o), 32'd0);
        repeat (8) tick();
        check("t1_nstarts", 32'(n_starts), 32'd1);
        check("t1_held", 32'(bus.tx_data_o), 32'hAA);

        // fill to 16, overflow, then drain in order across the pointer wrap
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) put(8'(i));
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        tick();
        check("t2_count", 32'(bus.fifo_count_o), 32'd16);
        check("t2_full", 32'(bus.fifo_full_o), 32'd1);
        check("t2_ready", 32'(bus.wr_ready_o), 32'd0);
        check("t2_ovf", 32'(bus.overflow_o), 32'd1);
        wr_valid = 1'b0;
        tick();
        check("t2_ovf_end", 32'(bus.overflow_o), 32'd0);
        check("t2_novf", 32'(n_ovf), 32'd1);
        sent.delete();
        tx_en = 1'b1;
        repeat (150) tick();
        check("t2_nsent", 32'(sent.size()), 32'd16);
        for (int i = 0; i < sent.size(); i++) check("t2_order", 32'(sent[i]), 32'(i));

        // flush with a frame in flight and three bytes behind it
        tx_en = 1'b0;
        put(8'h31); put(8'h32); put(8'h33); put(8'h34);
        s0    = n_starts;
        tx_en = 1'b1;
        tick();
        check("t3_data", 32'(bus.tx_data_o), 32'h31);
        check("t3_count_pre", 32'(bus.fifo_count_o), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_count", 32'(bus.fifo_count_o), 32'd0);
        repeat (20) tick();
        check("t3_nstarts", 32'(n_starts), 32'(s0 + 1));
        check("t3_held", 32'(bus.tx_data_o), 32'h31);

        // transmitter busy blocks the start until it drops
        s1       = n_starts;
        man_busy = 1'b1;
        put(8'h41); put(8'h42);
        repeat (4) tick();
        check("t4_blocked", 32'(n_starts), 32'(s1));
        man_busy = 1'b0;
        tick();
        check("t4_start", 32'(bus.tx_start_o), 32'd1);
        check("t4_data", 32'(bus.tx_data_o), 32'h41);
        repeat (30) tick();
        check("t4_nstarts", 32'(n_starts), 32'(s1 + 2));

        // push and pop in the same cycle at count 5
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) put(8'(8'h50 + i));
        check("t5_count5", 32'(bus.fifo_count_o), 32'd5);
        tx_en    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        check("t5_count_same", 32'(bus.fifo_count_o), 32'd5);
        check("t5_start", 32'(bus.tx_start_o), 32'd1);
        check("t5_data", 32'(bus.tx_data_o), 32'h50);
        repeat (60) tick();
        check("t5_drained", 32'(bus.fifo_count_o), 32'd0);

        // asynchronous reset in the middle of a frame
        put(8'h66);
        tick();
        check("t6_data", 32'(bus.tx_data_o), 32'h66);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_data", 32'(bus.tx_data_o), 32'd0);
        check("t6_rst_start", 32'(bus.tx_start_o), 32'd0);
        check("t6_rst_empty", 32'(bus.fifo_empty_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        repeat (10) tick();

        // stalled transmitter: watchdog recovery, or an indefinite wait without it
        auto_tx = 1'b0;
        put(8'h77);
        put(8'h78);
        check("t7_start", 32'(bus.tx_start_o), 32'd1);
        check("t7_data", 32'(bus.tx_data_o), 32'h77);
`ifdef TX_WATCHDOG_EN
        hit = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.tx_timeout_o) begin
                hit = i;
                break;
            end
        end
        check("t7_wdog_delay", 32'(hit), 32'd100);
        tick();
        check("t7_next_start", 32'(bus.tx_start_o), 32'd1);
        check("t7_next_data", 32'(bus.tx_data_o), 32'h78);
        repeat (110) tick();
        check("t7_nto", 32'(n_to), 32'd2);
`else
        hit = 0;
        tick();
        s0 = n_starts;
        repeat (149) tick();
        check("t7_no_to", 32'(n_to), 32'(hit));
        check("t7_waiting", 32'(n_starts), 32'(s0));
        check("t7_held", 32'(bus.tx_data_o), 32'h77);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        check("t7_next_start", 32'(bus.tx_start_o), 32'd1);
        check("t7_next_data", 32'(bus.tx_data_o), 32'h78);
        repeat (3) tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (3) tick();
`endif
        check("end_empty", 32'(bus.fifo_empty_o), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
